// File: rtl/kmeans_centroid_sorter_if.sv
// Stream bundle between the k-means core output, the centroid sorter and its host.
// in_* is a plain beat strobe with no backpressure. A beat on out_* moves on a clock edge only when out_valid && out_ready; out_* stays stable while stalled.
interface kmeans_centroid_sorter_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_idx;
   logic              out_last;
   logic              dup_flag;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_idx, out_last, dup_flag
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_idx, out_last, dup_flag
   );
endinterface

// File: rtl/kmeans_centroid_sorter.sv
// Captures a 4-beat centroid burst and sorts it with a 4-pass odd-even transposition network.
// The sorted frame is replayed in rank order on a valid/ready stream with a duplicate flag.
module kmeans_centroid_sorter #(
   parameter int NUM_CLUSTERS    = 4,
   parameter int DATA_W          = 16,
   parameter bit SORT_DESCENDING = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   kmeans_centroid_sorter_if.slave bus,
   output logic                   busy,
   output logic                   frame_err,
   output logic                   overrun_err,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SORT    = 2'd2,
      OUT     = 2'd3
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'(NUM_CLUSTERS - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] buf_q [NUM_CLUSTERS];
   logic [DATA_W-1:0] buf_d [NUM_CLUSTERS];
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        pass_q, pass_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [1:0]        out_idx_q, out_idx_d;
   logic              out_last_q, out_last_d;
   logic              dup_q, dup_d;
   logic              busy_q, busy_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_err_q, overrun_err_d;

   // Equal words never swap, which keeps the network stable.
   function automatic logic need_swap(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi);
      return SORT_DESCENDING ? (lo < hi) : (lo > hi);
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pass_d        = pass_q;
      for (int i = 0; i < NUM_CLUSTERS; i++) buf_d[i] = buf_q[i];
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_idx_d     = out_idx_q;
      out_last_d    = out_last_q;
      dup_d         = dup_q;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               buf_d[0] = bus.in_data;
               cnt_d    = 2'd1;
               state_d  = CAPTURE;
            end
         end
         CAPTURE: begin
            if (bus.in_valid) begin
               buf_d[cnt_q] = bus.in_data;
               cnt_d        = cnt_q + 2'd1;
               if (cnt_q == LAST_IDX) begin
                  state_d = SORT;
                  pass_d  = 2'd0;
               end
            end else begin
               frame_err_d = 1'b1;
               cnt_d       = 2'd0;
               state_d     = IDLE;
            end
         end
         SORT: begin
            overrun_err_d = bus.in_valid;
            if (!pass_q[0]) begin
               if (need_swap(buf_q[0], buf_q[1])) begin
                  buf_d[0] = buf_q[1];
                  buf_d[1] = buf_q[0];
               end
               if (need_swap(buf_q[2], buf_q[3])) begin
                  buf_d[2] = buf_q[3];
                  buf_d[3] = buf_q[2];
               end
            end else if (need_swap(buf_q[1], buf_q[2])) begin
               buf_d[1] = buf_q[2];
               buf_d[2] = buf_q[1];
            end
            pass_d = pass_q + 2'd1;
            // Last pass: load rank 0 and judge duplicates on the fully sorted words.
            if (pass_q == LAST_IDX) begin
               state_d     = OUT;
               out_valid_d = 1'b1;
               out_data_d  = buf_d[0];
               out_idx_d   = 2'd0;
               out_last_d  = 1'b0;
               dup_d       = (buf_d[0] == buf_d[1]) | (buf_d[1] == buf_d[2]) |
                             (buf_d[2] == buf_d[3]);
            end
         end
         OUT: begin
            overrun_err_d = bus.in_valid;
            if (out_valid_q && bus.out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  dup_d       = 1'b0;
                  state_d     = IDLE;
               end else begin
                  out_idx_d  = out_idx_q + 2'd1;
                  out_data_d = buf_q[out_idx_q + 2'd1];
                  out_last_d = ((out_idx_q + 2'd1) == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 2'd0;
         pass_q        <= 2'd0;
         for (int i = 0; i < NUM_CLUSTERS; i++) buf_q[i] <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_idx_q     <= 2'd0;
         out_last_q    <= 1'b0;
         dup_q         <= 1'b0;
         busy_q        <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pass_q        <= pass_d;
         for (int i = 0; i < NUM_CLUSTERS; i++) buf_q[i] <= buf_d[i];
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_idx_q     <= out_idx_d;
         out_last_q    <= out_last_d;
         dup_q         <= dup_d;
         busy_q        <= busy_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign bus.dup_flag  = dup_q;
   assign busy          = busy_q;
   assign frame_err     = frame_err_q;
   assign overrun_err   = overrun_err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_kmeans_centroid_sorter.sv
// Bench for kmeans_centroid_sorter: an ascending and a descending instance, a sorted-frame
// model feeding an expected queue, and a negedge compare process over both output streams.
module tb_kmeans_centroid_sorter;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   kmeans_centroid_sorter_if #(.DATA_W(W)) ifa ();
   kmeans_centroid_sorter_if #(.DATA_W(W)) ifd ();

   logic       busy_a, ferr_a, oerr_a, busy_d, ferr_d, oerr_d;
   logic [1:0] st_a, st_d;

   kmeans_centroid_sorter #(.NUM_CLUSTERS(4), .DATA_W(W), .SORT_DESCENDING(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a),
      .frame_err(ferr_a), .overrun_err(oerr_a), .state_dbg(st_a));

   kmeans_centroid_sorter #(.NUM_CLUSTERS(4), .DATA_W(W), .SORT_DESCENDING(1'b1)) dut_d (
      .clk(clk), .rst_n(rst_n), .bus(ifd), .busy(busy_d),
      .frame_err(ferr_d), .overrun_err(oerr_d), .state_dbg(st_d));

   // Entry: {dut, dup, last, idx[1:0], data[15:0]}
   logic [20:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int hs_a = 0;
   int hs_d = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns {dup, rank0, rank1, rank2, rank3} for frame {beat0, beat1, beat2, beat3}.
   function automatic logic [64:0] model_frame(input bit desc, input logic [63:0] frame);
      logic [15:0] v [4];
      logic [15:0] t;
      logic        dup;
      for (int i = 0; i < 4; i++) v[i] = frame[63-16*i -: 16];
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
               t = v[i]; v[i] = v[j]; v[j] = t;
            end
      dup = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (v[i] == v[j]) dup = 1'b1;
      return {dup, v[0], v[1], v[2], v[3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input int k, input logic v, input logic [15:0] d);
      if (k == 0) begin ifa.in_valid = v; ifa.in_data = d; end
      else        begin ifd.in_valid = v; ifd.in_data = d; end
   endtask

   task automatic set_ready(input int k, input logic r);
      if (k == 0) ifa.out_ready = r;
      else        ifd.out_ready = r;
   endtask

   function automatic logic is_valid(input int k);
      return (k == 0) ? ifa.out_valid : ifd.out_valid;
   endfunction

   function automatic logic is_busy(input int k);
      return (k == 0) ? busy_a : busy_d;
   endfunction

   task automatic send_frame(input int k, input logic [63:0] f);
      logic [64:0] r;
      logic [1:0]  ii;
      for (int i = 0; i < 4; i++) begin
         drive_in(k, 1'b1, f[63-16*i -: 16]);
         tick();
      end
      drive_in(k, 1'b0, 16'h0000);
      r = model_frame(k == 1, f);
      for (int i = 0; i < 4; i++) begin
         ii = 2'(i);
         exp_q.push_back({(k == 1), r[64], (i == 3), ii, r[63-16*i -: 16]});
      end
   endtask

   task automatic wait_valid(input int k, output int n);
      n = 0;
      while (!is_valid(k) && n < 50) begin tick(); n++; end
      if (!is_valid(k)) begin
         checks++; errors++;
         $display("FAIL wait_valid dut%0d: got timeout expected out_valid", k);
      end
   endtask

   task automatic wait_idle(input int k, output int n);
      n = 0;
      while (is_busy(k) && n < 50) begin tick(); n++; end
      if (is_busy(k)) begin
         checks++; errors++;
         $display("FAIL wait_idle dut%0d: got busy expected idle", k);
      end
   endtask

   task automatic drain(input int k);
      int n;
      wait_idle(k, n);
      check("drain_queue_empty", 65'(exp_q.size()), 65'd0);
   endtask

   task automatic cmp_port(input int k, input logic v, input logic r, input logic [15:0] d,
                           input logic [1:0] idx, input logic last, input logic dup);
      logic [20:0] e;
      logic [31:0] kk;
      kk = k;
      if (v) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat dut%0d: got %0h expected none", k, d);
         end else begin
            e = exp_q[0];
            if (e[20] != kk[0]) begin
               checks++; errors++;
               $display("FAIL beat_owner dut%0d: got %0h expected none", k, d);
            end else begin
               check("out_data", 65'(d), 65'(e[15:0]));
               check("out_idx", 65'(idx), 65'(e[17:16]));
               check("out_last", 65'(last), 65'(e[18]));
               check("dup_flag", 65'(dup), 65'(e[19]));
               if (r) begin
                  void'(exp_q.pop_front());
                  if (k == 0) hs_a++;
                  else        hs_d++;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         cmp_port(0, ifa.out_valid, ifa.out_ready, ifa.out_data, ifa.out_idx, ifa.out_last, ifa.dup_flag);
         cmp_port(1, ifd.out_valid, ifd.out_ready, ifd.out_data, ifd.out_idx, ifd.out_last, ifd.dup_flag);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int hs0;
      rst_n = 1'b0;
      drive_in(0, 1'b0, 16'h0000);
      drive_in(1, 1'b0, 16'h0000);
      set_ready(0, 1'b0);
      set_ready(1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 65'(ifa.out_valid), 65'd0);
      check("rst_out_data", 65'(ifa.out_data), 65'd0);
      check("rst_out_idx", 65'(ifa.out_idx), 65'd0);
      check("rst_flags", 65'({busy_a, ferr_a, oerr_a, ifa.dup_flag, ifa.out_last}), 65'd0);
      check("rst_state", 65'(st_a), 65'd0);
      check("rst_desc_busy", 65'(busy_d), 65'd0);
      rst_n = 1'b1;
      tick();

      check("model_pin_asc", model_frame(1'b0, {16'h8040, 16'h1020, 16'hFF00, 16'h1010}),
            {1'b0, 16'h1010, 16'h1020, 16'h8040, 16'hFF00});
      check("model_pin_desc", model_frame(1'b1, {16'h2222, 16'h0001, 16'h2222, 16'h0100}),
            {1'b1, 16'h2222, 16'h2222, 16'h0100, 16'h0001});
      check("model_pin_rev", model_frame(1'b0, {16'h0003, 16'h0002, 16'h0001, 16'h0000}),
            {1'b0, 16'h0000, 16'h0001, 16'h0002, 16'h0003});

      // Ascending, no backpressure: latency and back-to-back beats
      set_ready(0, 1'b1);
      send_frame(0, {16'h8040, 16'h1020, 16'hFF00, 16'h1010});
      check("busy_after_capture", 65'(busy_a), 65'd1);
      wait_valid(0, n);
      check("latency_edges", 65'(n), 65'd4);
      check("first_beat_literal", 65'(ifa.out_data), 65'h1010);
      check("state_out", 65'(st_a), 65'd3);
      wait_idle(0, n);
      check("drain_edges", 65'(n), 65'd4);
      check("drain_queue_empty", 65'(exp_q.size()), 65'd0);

      // Backpressure: 3 stalled cycles, then 1,0,1,1, then ready held
      set_ready(0, 1'b0);
      hs0 = hs_a;
      send_frame(0, {16'h8040, 16'h1020, 16'hFF00, 16'h1010});
      wait_valid(0, n);
      repeat (3) tick();
      check("stall_hold", 65'(ifa.out_data), 65'h1010);
      set_ready(0, 1'b1); tick();
      set_ready(0, 1'b0); tick();
      set_ready(0, 1'b1); tick();
      tick();
      drain(0);
      check("bp_handshakes", 65'(hs_a - hs0), 65'd4);

      // Descending with duplicates
      set_ready(1, 1'b1);
      send_frame(1, {16'h2222, 16'h0001, 16'h2222, 16'h0100});
      wait_valid(1, n);
      check("desc_first_literal", 65'(ifd.out_data), 65'h2222);
      check("desc_dup_literal", 65'(ifd.dup_flag), 65'd1);
      drain(1);
      check("desc_dup_cleared", 65'(ifd.dup_flag), 65'd0);

      // Aborted capture then a full frame
      set_ready(0, 1'b1);
      drive_in(0, 1'b1, 16'h1111); tick();
      drive_in(0, 1'b1, 16'h2222); tick();
      drive_in(0, 1'b0, 16'h0000); tick();
      check("frame_err_pulse", 65'(ferr_a), 65'd1);
      check("abort_busy", 65'(busy_a), 65'd0);
      check("abort_no_valid", 65'(ifa.out_valid), 65'd0);
      tick();
      check("frame_err_clear", 65'(ferr_a), 65'd0);
      send_frame(0, {16'h0003, 16'h0002, 16'h0001, 16'h0000});
      drain(0);

      // Overrun during SORT and during OUT
      set_ready(0, 1'b0);
      send_frame(0, {16'h8040, 16'h1020, 16'hFF00, 16'h1010});
      drive_in(0, 1'b1, 16'hABCD); tick();
      check("overrun_sort", 65'(oerr_a), 65'd1);
      drive_in(0, 1'b0, 16'h0000); tick();
      check("overrun_sort_clear", 65'(oerr_a), 65'd0);
      wait_valid(0, n);
      drive_in(0, 1'b1, 16'hABCD); tick();
      check("overrun_out", 65'(oerr_a), 65'd1);
      drive_in(0, 1'b0, 16'h0000); tick();
      check("overrun_out_clear", 65'(oerr_a), 65'd0);
      set_ready(0, 1'b1);
      drain(0);

      // Asynchronous reset during SORT pass 2
      send_frame(0, {16'h0003, 16'h0002, 16'h0001, 16'h0000});
      tick(); tick();
      check("pre_reset_sort", 65'(st_a), 65'd2);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_sort_busy", 65'(busy_a), 65'd0);
      check("rst_sort_state", 65'(st_a), 65'd0);
      check("rst_sort_data", 65'(ifa.out_data), 65'd0);
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", 65'(busy_a), 65'd0);

      // Asynchronous reset during OUT with out_valid high
      set_ready(0, 1'b0);
      send_frame(0, {16'h8040, 16'h1020, 16'hFF00, 16'h1010});
      wait_valid(0, n);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_out_valid_mid", 65'(ifa.out_valid), 65'd0);
      check("rst_out_data_mid", 65'(ifa.out_data), 65'd0);
      check("rst_out_misc_mid", 65'({ifa.out_idx, ifa.out_last, ifa.dup_flag, busy_a}), 65'd0);
      rst_n = 1'b1;
      tick();
      set_ready(0, 1'b1);
      send_frame(0, {16'h1234, 16'h0042, 16'h1234, 16'h00FF});
      drain(0);

      check("final_queue_empty", 65'(exp_q.size()), 65'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kmeans_centroid_sorter.md
Name: kmeans_centroid_sorter

Overview:
- Downstream consumer of the k-means clustering core.
- Captures the 4-beat final-centroid burst (packed {x[7:0], y[7:0]}) that the core emits on out_valid/out_data.
- Sorts the centroids into canonical order with a sequential odd-even transposition network, flags duplicate centroids, and presents them on a valid/ready stream, so results are order-independent for the host and scoreboard.

Parameters:
- NUM_CLUSTERS, 4, number of centroid beats per frame; only 4 is supported, and the index width is 2.
- DATA_W, 16, centroid word width; x is in [DATA_W-1:DATA_W/2], y is in [DATA_W/2-1:0].
- SORT_DESCENDING, 0, 0 sorts ascending by the full unsigned word (x major, y minor); 1 sorts descending.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  centroid beat valid; connects to the core's out_valid.
- in_data  input  DATA_W  centroid beat; connects to the core's out_data.
- out_valid  output  1  sorted centroid available.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  DATA_W  sorted centroid.
- out_idx  output  2  rank of out_data within the frame (0..3).
- out_last  output  1  high with the rank-3 beat.
- dup_flag  output  1  frame contains two or more identical centroids; valid whenever out_valid is high.
- busy  output  1  state is not IDLE.
- frame_err  output  1  one-cycle pulse: capture aborted by a gap in in_valid.
- overrun_err  output  1  one-cycle pulse: in_valid seen in SORT or OUT; the beat is dropped.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - out_valid, out_last, dup_flag, busy, frame_err and overrun_err all go to 0.
  - out_data, out_idx, the capture buffer buf[0..3], the beat counter and the pass counter all go to 0.
  - Reset asserted mid-operation discards the frame; no partial output follows.
- All outputs are registered.
- States: IDLE, CAPTURE, SORT, OUT.
- IDLE:
  - in_valid=1: buf[0]<=in_data, cnt<=1, go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE:
  - in_valid=1: buf[cnt]<=in_data and cnt increments. When cnt==3 is written, go to SORT with pass<=0.
  - in_valid=0 before the 4th beat: pulse frame_err, clear cnt, go to IDLE. The partial frame is discarded.
- SORT: one compare-exchange pass per cycle, for exactly 4 passes (pass 0..3).
  - Even passes compare pairs (0,1) and (2,3).
  - Odd passes compare pair (1,2).
  - Swap when buf[lo]>buf[hi] if ascending, or buf[lo]<buf[hi] if descending. Equal values are never swapped, so the sort is stable.
  - Comparison is unsigned over the full DATA_W bits.
  - After pass 3:
    - go to OUT;
    - out_valid<=1, out_data<=buf[0], out_idx<=0, out_last<=0;
    - dup_flag <= (buf0==buf1)|(buf1==buf2)|(buf2==buf3), evaluated on the final sorted values.
- OUT:
  - out_data/out_idx/out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready with idx<3: idx increments, out_data<=buf[idx+1], and out_last<=(idx+1==3).
  - On a handshake with out_last=1: out_valid, out_last and dup_flag go to 0 on that edge, and the state returns to IDLE.
  - out_ready is ignored while out_valid=0.
- Latency:
  - Edge E0 samples the 4th input beat.
  - Passes run on E1..E4.
  - out_valid is high after edge E4.
  - With out_ready held high, the 4 output beats are on consecutive cycles and the module is back in IDLE after E8.
  - A new frame may start in IDLE on the cycle after the last handshake.
- Overrun: in_valid=1 in SORT or OUT pulses overrun_err for one cycle; the beat is ignored and the current frame is unaffected.
- Simultaneous events: last output handshake and in_valid in the same cycle counts as overrun; that beat is dropped. IDLE only accepts a beat in the following cycle.
- busy=1 in CAPTURE, SORT and OUT.

Test Plan:
- Ascending sort with backpressure off:
  - Stimulus: frame 0x8040, 0x1020, 0xFF00, 0x1010 with out_ready=1.
  - Response: out_data 0x1010, 0x1020, 0x8040, 0xFF00 on 4 consecutive cycles; out_idx 0..3; out_last only on 0xFF00; dup_flag=0; first out_valid 4 edges after the 4th beat is sampled.
- Backpressure:
  - Stimulus: same frame; out_ready=0 for 3 cycles after out_valid rises, then a pattern of 1,0,1,1.
  - Response: out_data holds 0x1010 while stalled, no beat is skipped or repeated, and exactly 4 handshakes occur.
- Duplicates and descending order:
  - Stimulus: frame 0x2222, 0x0001, 0x2222, 0x0100 with SORT_DESCENDING=1.
  - Response: 0x2222, 0x2222, 0x0100, 0x0001 with dup_flag=1 for the whole frame.
- Aborted capture:
  - Stimulus: 2 beats, then in_valid=0.
  - Response: frame_err pulses for 1 cycle, there is no out_valid, and busy=0. The next full frame 0x0003, 0x0002, 0x0001, 0x0000 outputs 0x0000..0x0003.
- Overrun:
  - Stimulus: in_valid=1 with 0xABCD during SORT and again during OUT.
  - Response: overrun_err pulses once for each, and the output frame is unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during SORT pass 2, and again during OUT with out_valid=1.
  - Response: all outputs go to 0 immediately, without waiting for a clock edge. After release the block is in IDLE and the next frame sorts correctly.
